jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_pkg.sv | 35 +++
 rtl/jk_cell.sv | 26 ++
 rtl/jk_reg_bank.sv | 107 ++++++++++
 tb/tb_jk_reg_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// JK register bank shared definitions: opcode type, opcode
// constants and the per-channel next-state function.
package jk_pkg;

   typedef logic [1:0] jk_op_t;

   localparam jk_op_t JK_HOLD   = 2'b00;
   localparam jk_op_t JK_RESET  = 2'b01;
   localparam jk_op_t JK_SET    = 2'b10;
   localparam jk_op_t JK_TOGGLE = 2'b11;

   // Next q for one channel, excluding reset: load > en opcode > hold.
   function automatic logic jk_next(
      input logic   q,
      input jk_op_t op,
      input logic   load,
      input logic   ld,
      input logic   en
   );
      logic n;
      n = q;
      if (load) begin
         n = ld;
      end else if (en) begin
         case (op)
            JK_RESET:  n = 1'b0;
            JK_SET:    n = 1'b1;
            JK_TOGGLE: n = ~q;
            default:   n = q;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK channel: a single registered bit with synchronous reset,
// parallel load and JK opcode.
module jk_cell
   import jk_pkg::*;
#(
   parameter logic RST_BIT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       load_data,
   input  logic       en,
   input  logic [1:0] op,
   output logic       q
);

   // Channel state register; reset wins over every other control.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RST_BIT;
      end else begin
         q <= jk_next(q, jk_op_t'(op), load, load_data, en);
      end
   end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK channels with a saturating toggle counter and
// optional sticky edge flags (enabled by JK_REG_BANK_STICKY_EN).
module jk_reg_bank
   import jk_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_rise,
   output logic [WIDTH-1:0] q_fall,
   output logic [CNT_W-1:0] toggle_cnt
);

   localparam int PW = $clog2(WIDTH + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         jk_cell #(
            .RST_BIT (RESET_VAL[gi])
         ) u_cell (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .load_data (load_data[gi]),
            .en        (en),
            .op        ({j[gi], k[gi]}),
            .q         (q[gi])
         );
      end
   endgenerate

   logic [WIDTH-1:0] tog;
   logic [PW-1:0]    pop;
   logic [SW-1:0]    base;
   logic [SW-1:0]    sum;
   logic [CNT_W-1:0] cnt_nx;

   // Count channels that really apply TOGGLE this cycle and saturate.
   always_comb begin
      tog  = {WIDTH{en & ~load}} & j & k;
      pop  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + PW'(tog[i]);
      end
      base = clr_flags ? '0 : SW'(toggle_cnt);
      sum  = base + SW'(pop);
      if (sum > SW'(CNT_MAX)) begin
         cnt_nx = CNT_MAX;
      end else begin
         cnt_nx = CNT_W'(sum);
      end
   end

   // Toggle counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         toggle_cnt <= '0;
      end else begin
         toggle_cnt <= cnt_nx;
      end
   end

`ifdef JK_REG_BANK_STICKY_EN
   logic [WIDTH-1:0] q_nx;
   logic [WIDTH-1:0] rise_r;
   logic [WIDTH-1:0] fall_r;

   // Next q of each channel, used to flag edges in the same cycle.
   always_comb begin
      q_nx = q;
      for (int i = 0; i < WIDTH; i++) begin
         q_nx[i] = jk_next(q[i], {j[i], k[i]}, load, load_data[i], en);
      end
   end

   // Sticky edge flags; a new edge beats a coincident clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         rise_r <= '0;
         fall_r <= '0;
      end else begin
         rise_r <= (clr_flags ? '0 : rise_r) | (~q & q_nx);
         fall_r <= (clr_flags ? '0 : fall_r) | (q & ~q_nx);
      end
   end

   assign q_rise = rise_r;
   assign q_fall = fall_r;
`else
   assign q_rise = '0;
   assign q_fall = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed testbench for jk_reg_bank (WIDTH=8, CNT_W=4).
// Flag expectations follow JK_REG_BANK_STICKY_EN.
module tb_jk_reg_bank;

`ifdef JK_REG_BANK_STICKY_EN
   localparam logic [7:0] FM = 8'hFF;
`else
   localparam logic [7:0] FM = 8'h00;
`endif

   logic       clk;
   logic       reset;
   logic       en;
   logic [7:0] j;
   logic [7:0] k;
   logic       load;
   logic [7:0] load_data;
   logic       clr_flags;
   logic [7:0] q;
   logic [7:0] q_rise;
   logic [7:0] q_fall;
   logic [3:0] toggle_cnt;

   int total;
   int bad;

   jk_reg_bank #(
      .WIDTH     (8),
      .CNT_W     (4),
      .RESET_VAL (8'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .j          (j),
      .k          (k),
      .load       (load),
      .load_data  (load_data),
      .clr_flags  (clr_flags),
      .q          (q),
      .q_rise     (q_rise),
      .q_fall     (q_fall),
      .toggle_cnt (toggle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic e, input logic [7:0] jj,
                        input logic [7:0] kk, input logic l,
                        input logic [7:0] ld, input logic c);
      reset = r; en = e; j = jj; k = kk;
      load = l; load_data = ld; clr_flags = c;
   endtask

   task automatic test_reset();
      drive(1, 1, 8'hFF, 8'hFF, 1, 8'hFF, 1);
      tick();
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'h00, 8'h00, 8'h00, 4'd0}) begin
         bad++;
         $display("FAIL reset: q=%h r=%h f=%h c=%0d want 00 00 00 0",
                  q, q_rise, q_fall, toggle_cnt);
      end
   endtask

   task automatic test_set();
      drive(0, 1, 8'hFF, 8'h00, 0, 8'h00, 0);
      #1;
      total++;
      if (q !== 8'h00) begin
         bad++;
         $display("FAIL no_comb_path: q=%h want 00", q);
      end
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'hFF, 8'hFF & FM, 8'h00, 4'd0}) begin
         bad++;
         $display("FAIL set: q=%h r=%h f=%h c=%0d want ff %h 00 0",
                  q, q_rise, q_fall, toggle_cnt, 8'hFF & FM);
      end
   endtask

   task automatic test_toggle_sat();
      logic [7:0] eq [5];
      logic [3:0] ec [5];
      eq = '{8'h00, 8'hF0, 8'h00, 8'hF0, 8'h00};
      ec = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
      drive(0, 1, 8'hF0, 8'hFF, 0, 8'h00, 0);
      tick();
      total++;
      if (q_fall !== (8'hFF & FM)) begin
         bad++;
         $display("FAIL tog_fall: f=%h want %h", q_fall, 8'hFF & FM);
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         total++;
         if ({q, toggle_cnt} !== {eq[i], ec[i]}) begin
            bad++;
            $display("FAIL tog_sat[%0d]: q=%h c=%0d want %h %0d",
                     i, q, toggle_cnt, eq[i], ec[i]);
         end
      end
   endtask

   task automatic test_load();
      drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'h00, 8'h00, 8'h00, 4'd0}) begin
         bad++;
         $display("FAIL clr: q=%h r=%h f=%h c=%0d want 00 00 00 0",
                  q, q_rise, q_fall, toggle_cnt);
      end
      drive(0, 1, 8'hFF, 8'hFF, 1, 8'hA5, 0);
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'hA5, 8'hA5 & FM, 8'h00, 4'd0}) begin
         bad++;
         $display("FAIL load: q=%h r=%h f=%h c=%0d want a5 %h 00 0",
                  q, q_rise, q_fall, toggle_cnt, 8'hA5 & FM);
      end
   endtask

   task automatic test_clr_edge();
      drive(0, 1, 8'h03, 8'h03, 0, 8'h00, 0);
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'hA6, 8'hA7 & FM, 8'h01 & FM, 4'd2}) begin
         bad++;
         $display("FAIL pre_clr: q=%h r=%h f=%h c=%0d want a6 %h %h 2",
                  q, q_rise, q_fall, toggle_cnt, 8'hA7 & FM, 8'h01 & FM);
      end
      drive(0, 1, 8'h01, 8'h00, 0, 8'h00, 1);
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'hA7, 8'h01 & FM, 8'h00, 4'd0}) begin
         bad++;
         $display("FAIL clr_edge: q=%h r=%h f=%h c=%0d want a7 %h 00 0",
                  q, q_rise, q_fall, toggle_cnt, 8'h01 & FM);
      end
      drive(0, 1, 8'h10, 8'h10, 0, 8'h00, 0);
      tick();
      total++;
      if ({q, q_rise, toggle_cnt} !== {8'hB7, 8'h11 & FM, 4'd1}) begin
         bad++;
         $display("FAIL tog_one: q=%h r=%h c=%0d want b7 %h 1",
                  q, q_rise, toggle_cnt, 8'h11 & FM);
      end
      drive(0, 1, 8'h80, 8'h80, 0, 8'h00, 1);
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'h37, 8'h00, 8'h80 & FM, 4'd1}) begin
         bad++;
         $display("FAIL clr_pop: q=%h r=%h f=%h c=%0d want 37 00 %h 1",
                  q, q_rise, q_fall, toggle_cnt, 8'h80 & FM);
      end
   endtask

   task automatic test_hold();
      drive(0, 0, 8'hFF, 8'hFF, 0, 8'hFF, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({q, q_rise, q_fall, toggle_cnt} !== {8'h37, 8'h00, 8'h80 & FM, 4'd1}) begin
            bad++;
            $display("FAIL hold[%0d]: q=%h r=%h f=%h c=%0d want 37 00 %h 1",
                     i, q, q_rise, q_fall, toggle_cnt, 8'h80 & FM);
         end
      end
      drive(0, 1, 8'h00, 8'h00, 0, 8'hFF, 0);
      tick();
      total++;
      if ({q, toggle_cnt} !== {8'h37, 4'd1}) begin
         bad++;
         $display("FAIL op_hold: q=%h c=%0d want 37 1", q, toggle_cnt);
      end
   endtask

   task automatic test_reset_mid();
      drive(1, 1, 8'hFF, 8'hFF, 1, 8'h5A, 1);
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'h00, 8'h00, 8'h00, 4'd0}) begin
         bad++;
         $display("FAIL reset_mid: q=%h r=%h f=%h c=%0d want 00 00 00 0",
                  q, q_rise, q_fall, toggle_cnt);
      end
      drive(0, 1, 8'h0F, 8'h0F, 0, 8'h00, 0);
      tick();
      total++;
      if ({q, q_rise, q_fall, toggle_cnt} !== {8'h0F, 8'h0F & FM, 8'h00, 4'd4}) begin
         bad++;
         $display("FAIL after_rst: q=%h r=%h f=%h c=%0d want 0f %h 00 4",
                  q, q_rise, q_fall, toggle_cnt, 8'h0F & FM);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      drive(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
      test_reset();
      test_set();
      test_toggle_sat();
      test_load();
      test_clr_edge();
      test_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
